// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus between the load/store unit and memory.
interface load_store_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_ready;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: IDLE -> ACCESS -> DONE handshake with data
// memory, byte-lane enables/replication for stores, extension for loads.

// One byte lane of the store path: enable bit and replicated data byte.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 0 byte, 1 half, 2 word
  input  logic [1:0]  off,    // byte offset within the word
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  // Lane select follows the access size; data is replicated so any lane sees it.
  always_comb begin
    be    = 1'b0;
    wbyte = wdata[8*LANE +: 8];
    case (size)
      2'd0: begin
        be    = (off == 2'(LANE));
        wbyte = wdata[7:0];
      end
      2'd1: begin
        be    = (off[1] == 1'(LANE / 2));
        wbyte = wdata[8*(LANE % 2) +: 8];
      end
      2'd2: be = 1'b1;
      default: be = 1'b0;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    stall,
  output logic                    done,
  output logic                    fault,
  output logic [DATA_WIDTH-1:0]   rdata_wb,
  load_store_unit_if.master       mem
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         go, legal, aligned, bad;
  logic [NUM_LANES-1:0]         be_d;
  logic [NUM_LANES-1:0][7:0]    wdata_d;
  logic [2:0]                   f3_q;
  logic [1:0]                   lane_q;
  logic [7:0]                   rbyte;
  logic [15:0]                  rhalf;
  logic [DATA_WIDTH-1:0]        ext;

  assign go = MemRead | MemWrite;

  // Legality: unsigned sizes exist only for loads; a store wins if both are set.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~MemWrite;
      default:                legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    bad = ~(legal & aligned);
  end

  // Store enables and lane-replicated data, one lane per byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size  (funct3[1:0]),
      .off   (addr[1:0]),
      .wdata (wdata),
      .be    (be_d[i]),
      .wbyte (wdata_d[i])
    );
  end

  // Next state plus the combinational stall/request outputs.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem.mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        stall = go;
        if (go) state_d = bad ? DONE : ACCESS;
      end
      ACCESS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extraction from the returned word using the latched size and lane.
  always_comb begin
    rbyte = mem.mem_rdata[{lane_q, 3'b000} +: 8];
    rhalf = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext = {24'd0, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = mem.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, registered done/fault, and write-back data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      f3_q          <= 3'd0;
      lane_q        <= 2'd0;
      done          <= 1'b0;
      fault         <= 1'b0;
      rdata_wb      <= '0;
    end else begin
      done  <= (state_d == DONE);
      fault <= (state_q == IDLE) & go & bad;
      if (state_q == IDLE && go && !bad) begin
        mem.mem_we    <= MemWrite;
        mem.mem_addr  <= {addr[ADDRESS_WIDTH-1:2], 2'b00};
        mem.mem_be    <= be_d;
        mem.mem_wdata <= wdata_d;
        f3_q          <= funct3;
        lane_q        <= addr[1:0];
      end
      if (state_q == IDLE && go && bad)
        rdata_wb <= '0;
      else if (state_q == ACCESS && mem.mem_ready && !mem.mem_we)
        rdata_wb <= ext;
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory stage sitting directly downstream of the register-file/ALU stage. It takes the ALU sum as the effective address and the second register operand as store data. It runs a request/ready handshake with the data memory, applying byte enables for stores and sign or zero extension for loads. While an access is in flight it stalls the core, then hands the load result back for register write-back.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width (only 32 supported)
- ADDRESS_WIDTH, 32, byte-address width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store (wins if both high)
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDRESS_WIDTH  effective byte address (ALU SUM)
- wdata  in  DATA_WIDTH  store data (register RD2)
- stall  out  1  hold PC and suppress RegWrite
- done  out  1  one-cycle pulse, access complete
- fault  out  1  valid with done: misaligned or illegal funct3
- rdata_wb  out  DATA_WIDTH  extended load result, valid when done=1
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDRESS_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_ready  in  1  memory accepts/completes request this cycle
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ready=1

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE, MemRead|MemWrite=0: remain in IDLE.
- IDLE, MemRead|MemWrite=1, legal and aligned: latch mem_we/addr/be/wdata and go to ACCESS.
- IDLE, MemRead|MemWrite=1, illegal funct3 (011/110/111, or any non-load/store-legal code) or misaligned (H with addr[0]=1; W with addr[1:0]≠0): go to DONE with fault latched. No memory request is issued.
- ACCESS: mem_req=1. On mem_ready=1, capture the extended mem_rdata (loads only) into rdata_wb and go to DONE. Otherwise hold.
- DONE: done=1 for one cycle, then go unconditionally to IDLE. MemRead/MemWrite still high in DONE belong to the same instruction and are ignored.
- stall = (IDLE & (MemRead|MemWrite)) | ACCESS. stall is 0 in DONE so the PC advances at the end of that cycle.
- Store byte enables (lane = addr[1:0]): B → 1 << lane; H → 0011 or 1100; W → 1111.
- Store data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Loads drive mem_be by the same rule as stores.
- Load extract: B/BU take the byte at lane, H/HU take halfword addr[1]. Sign-extend for B/H, zero-extend for BU/HU. W is passed through.
- On fault: rdata_wb=0 and no write occurs.
- rdata_wb holds its value until the next DONE. Stores leave rdata_wb unchanged.

## Timing
- Reset (async assert): state=IDLE immediately. mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, fault, rdata_wb all 0. stall then follows its combinational equation.
- Reset during ACCESS: mem_req drops without waiting for the edge. The abandoned access is not retried.
- mem_addr/mem_be/mem_wdata/mem_we are registered and stable for the whole time mem_req=1.
- mem_ready is ignored outside ACCESS.
- Minimum latency, legal access: 3 cycles (IDLE request cycle, ACCESS with mem_ready=1, DONE). stall is high for 2 cycles.
- Each extra cycle with mem_ready=0 adds one cycle to both the latency and the stall.
- Fault path: 2 cycles (IDLE, DONE). stall is high for 1 cycle.
- done and fault are registered outputs, high only in DONE.

## Test plan
- LW addr=0x100, mem_ready high in the first ACCESS cycle, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_be=1111, stall high 2 cycles, done pulse, rdata_wb=0xDEADBEEF.
- SB addr=0x203, wdata=0x123456AB → mem_we=1, mem_addr=0x200, mem_be=1000, mem_wdata=0xABABABAB, rdata_wb unchanged.
- LH addr=0x102, 3 wait cycles then mem_ready=1 with mem_rdata=0x8001_0000 → rdata_wb=0xFFFF8001, stall high 5 cycles, request signals stable throughout.
- LBU addr=0x101, mem_rdata=0x0000F000 → rdata_wb=0x000000F0. LB at the same address → 0xFFFFFFF0.
- LW addr=0x102, then funct3=011 → each: no mem_req, done and fault high together one cycle after the request, rdata_wb=0.
- rst asserted mid-ACCESS (mem_ready=0) → mem_req falls same cycle, state IDLE, no done. After release, a new LW completes normally.
